// File: rtl/mig_write_feeder.sv
// Feeds 128-bit stacker chunks into the MIG user interface as one write command
// plus one single-beat write-data burst per chunk, with linear frame addressing.
module mig_write_feeder #(
  parameter int ADDR_W       = 27,
  parameter int ADDR_STEP    = 8,
  parameter int FRAME_CHUNKS = 4800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              chunk_tvalid,
  output logic              chunk_tready,
  input  logic [127:0]      chunk_tdata,
  input  logic              chunk_tlast,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [127:0]      app_wdf_data,
  output logic [15:0]       app_wdf_mask,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  output logic              frame_done
);

  localparam int                CNT_W    = (FRAME_CHUNKS > 1) ? $clog2(FRAME_CHUNKS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_CHUNKS - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);

  logic              hold_valid;
  logic              cmd_done;
  logic              data_done;
  logic [127:0]      hold_data;
  logic              hold_last;
  logic [ADDR_W-1:0] hold_addr;
  logic [ADDR_W-1:0] addr_cnt;
  logic [CNT_W-1:0]  chunk_cnt;

  logic cmd_fire;
  logic data_fire;
  logic finish;
  logic accept;
  logic wrap;

  assign app_en       = hold_valid && !cmd_done && init_calib_complete;
  assign app_wdf_wren = hold_valid && !data_done && init_calib_complete;
  assign app_wdf_end  = app_wdf_wren;
  assign app_cmd      = 3'b000;
  assign app_wdf_mask = '0;
  assign app_addr     = hold_addr;
  assign app_wdf_data = hold_data;

  assign cmd_fire  = app_en && app_rdy;
  assign data_fire = app_wdf_wren && app_wdf_rdy;
  assign finish    = hold_valid && (cmd_done || cmd_fire) && (data_done || data_fire);

  // Combinational through finish so a draining entry can be replaced in the same cycle.
  assign chunk_tready = !hold_valid || finish;
  assign accept       = chunk_tvalid && chunk_tready;
  assign wrap         = chunk_tlast || (chunk_cnt == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      cmd_done   <= 1'b0;
      data_done  <= 1'b0;
      addr_cnt   <= '0;
      chunk_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= finish && hold_last;

      if (accept)
        hold_valid <= 1'b1;
      else if (finish)
        hold_valid <= 1'b0;

      if (finish) begin
        cmd_done  <= 1'b0;
        data_done <= 1'b0;
      end else begin
        if (cmd_fire)  cmd_done  <= 1'b1;
        if (data_fire) data_done <= 1'b1;
      end

      if (accept) begin
        if (wrap) begin
          addr_cnt  <= '0;
          chunk_cnt <= '0;
        end else begin
          addr_cnt  <= addr_cnt + STEP;
          chunk_cnt <= chunk_cnt + 1'b1;
        end
      end
    end
  end

  // NOTE: the payload register carries no reset; it is qualified by hold_valid,
  // so resetting 150+ data flops would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= chunk_tdata;
      hold_last <= chunk_tlast;
      hold_addr <= addr_cnt;
    end
  end

endmodule

// File: doc/mig_write_feeder.md
Name: mig_write_feeder

Overview:
- Consumes the 128-bit chunk stream produced by the pixel stacker and writes each chunk to DDR through the MIG user interface.
- For each chunk it issues one write command (app_en/app_cmd/app_addr) and one write-data beat (app_wdf_*).
- Addresses are generated linearly and restart at a frame base on chunk_tlast.
- It sits between the stacker and the MIG UI port on the ui_clk domain.

Parameters:
- ADDR_W, 27, MIG app_addr width.
- ADDR_STEP, 8, app_addr increment per 128-bit chunk (BL8 on a x16 device).
- FRAME_CHUNKS, 4800, chunks per frame. Used as an address wrap guard if tlast is missing.

Ports:
- clk  in  1  MIG ui_clk.
- rst_n  in  1  asynchronous active-low reset.
- init_calib_complete  in  1  MIG calibration done. No command or data is issued while low.
- chunk_tvalid  in  1  upstream chunk valid.
- chunk_tready  out  1  upstream ready.
- chunk_tdata  in  128  chunk payload.
- chunk_tlast  in  1  last chunk of frame.
- app_addr  out  ADDR_W  MIG command address.
- app_cmd  out  3  MIG command; constant 3'b000 (write).
- app_en  out  1  command valid.
- app_rdy  in  1  MIG command ready.
- app_wdf_data  out  128  write data.
- app_wdf_mask  out  16  byte mask; constant 0.
- app_wdf_wren  out  1  write-data valid.
- app_wdf_end  out  1  equals app_wdf_wren (single-beat bursts).
- app_wdf_rdy  in  1  MIG write-data ready.
- frame_done  out  1  one-cycle pulse when the tlast chunk completes both handshakes.

Behaviour:
- Reset is asynchronous on rst_n low. The following clear to 0: hold_valid, cmd_done, data_done, addr counter, chunk counter, app_en, app_wdf_wren, frame_done.
- hold_data and hold_last are don't-care while hold_valid=0.
- Holding register: one entry holds hold_data, hold_last and hold_addr.
  - cmd_fire = app_en && app_rdy.
  - data_fire = app_wdf_wren && app_wdf_rdy.
- Output drive:
  - app_en = hold_valid && !cmd_done && init_calib_complete.
  - app_wdf_wren = hold_valid && !data_done && init_calib_complete.
  - app_addr = hold_addr; app_wdf_data = hold_data.
- Per-entry completion:
  - The command and data channels complete independently and in either order, including the same cycle.
  - A fire sets the matching done flag.
  - finish = hold_valid && (cmd_done || cmd_fire) && (data_done || data_fire).
  - On finish, both flags clear.
- Upstream handshake:
  - chunk_tready = !hold_valid || finish. This path is combinational from app_rdy/app_wdf_rdy.
  - accept = chunk_tvalid && chunk_tready. On accept, load data, last and the current address, and set hold_valid.
  - On finish without accept, clear hold_valid.
  - Back-to-back chunks therefore sustain one chunk per cycle when both MIG readies stay high.
- Address counter:
  - Advances on accept.
  - If chunk_tlast, or chunk count == FRAME_CHUNKS-1: next address = 0 and chunk count = 0.
  - Otherwise: address += ADDR_STEP and count += 1.
  - Address arithmetic is modulo 2^ADDR_W.
- frame_done is registered and asserts the cycle after a finish whose hold_last=1.
- Latency: a chunk accepted at cycle N drives app_en/app_wdf_wren from cycle N+1.
- Boundary cases:
  - init_calib_complete low: the entry is held, chunk_tready=0 while full, and no MIG strobes are driven.
  - Calibration dropping mid-entry keeps any already-set done flags.
  - MIG readies toggling: outputs stay stable while their strobe is high and unaccepted (AXI-style no-retraction).
  - Reset mid-operation: the in-flight chunk is dropped, the address restarts at 0, and no partial-handshake state survives.

Test Plan:
- Calib high, app_rdy=app_wdf_rdy=1, 3 chunks back-to-back (data A,B,C; tlast on C) -> app_addr 0,8,16 on consecutive cycles; data beats match; frame_done pulses once after C; the next chunk goes to addr 0.
- app_wdf_rdy=1, app_rdy held 0 for 4 cycles on first chunk -> data fires cycle 1 and app_wdf_wren drops; app_en stays high with addr 0; chunk_tready=0 until app_rdy rises; the second chunk is accepted that same cycle.
- app_rdy=1, app_wdf_rdy delayed 3 cycles -> command fires first and app_en drops; the entry completes on the data fire; exactly one command and one data beat per chunk.
- FRAME_CHUNKS=4, no tlast, 6 chunks -> addresses 0,8,16,24,0,8; frame_done never asserts.
- init_calib_complete=0 with chunk_tvalid=1 -> one chunk is accepted, then chunk_tready=0; no app_en/app_wdf_wren; on calib rise both strobe with addr 0.
- rst_n pulsed low while an entry is half-complete (cmd done, data pending) -> all strobes drop immediately; after release the next chunk writes to addr 0 with both handshakes fresh.
